// File: rtl/tdc_wb_reader_if.sv
// Wishbone classic bus bundle between the timestamp reader (master) and the
// opentdc_wb register slave.
//   wbm_cyc_o / wbm_stb_o : cycle and strobe, driven together by the master
//   wbm_we_o              : write enable (reads only, so always 0)
//   wbm_sel_o             : byte selects, 4'hF during a cycle
//   wbm_adr_o             : transaction address, 0 when idle
//   wbm_dat_o             : write data (unused, tied 0)
//   wbm_dat_i             : read data from the slave
//   wbm_ack_i             : slave acknowledge
interface tdc_wb_reader_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o,
    output wbm_stb_o,
    output wbm_we_o,
    output wbm_sel_o,
    output wbm_adr_o,
    output wbm_dat_o,
    input  wbm_dat_i,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o,
    input  wbm_stb_o,
    input  wbm_we_o,
    input  wbm_sel_o,
    input  wbm_adr_o,
    input  wbm_dat_o,
    output wbm_dat_i,
    output wbm_ack_i
  );
endinterface

// File: rtl/tdc_wb_reader.sv
// Wishbone classic single-read initiator that drains timestamps from the
// opentdc_wb slave. It polls the status register and, when bit 0 reports a
// pending timestamp and there is room locally, reads the time register and
// pushes the word into a first-word-fall-through FIFO.
// Ports:
//   wb_clk_i      : the only clock
//   wb_rst_i      : asynchronous active-high reset
//   enable_i      : polling enable, sampled only while idle
//   clr_i         : clears err_timeout_o (a same-edge timeout wins)
//   wbm           : Wishbone master side of the bus
//   fifo_rd_i     : pop the head entry (ignored when empty)
//   fifo_dat_o    : head entry, 0 when empty
//   fifo_empty_o  : FIFO empty flag
//   fifo_full_o   : FIFO full flag
//   err_timeout_o : sticky ack-timeout flag
module tdc_wb_reader #(
  parameter logic [31:0] ADDR_STATUS = 32'h3000_0000,
  parameter logic [31:0] ADDR_TIME   = 32'h3000_0004,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  input  logic                  clr_i,
  tdc_wb_reader_if.master       wbm,
  input  logic                  fifo_rd_i,
  output logic [31:0]           fifo_dat_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  err_timeout_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  // Counter value seen on the TIMEOUT-th edge after the strobe went high.
  localparam logic [7:0]  TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdStatus,
    StChk,
    StRdTime,
    StPush
  } state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        data_q, data_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               err_q, err_d;
  logic               push;
  logic               pop;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;

  // Bus outputs come straight from registers; idle values are all zero.
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = {4{cyc_q}};
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = 32'h0;

  assign err_timeout_o = err_q;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    data_d    = data_q;
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    push      = 1'b0;

    if (clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i && !fifo_full_o) begin
          state_d   = StRdStatus;
          cyc_d     = 1'b1;
          adr_d     = ADDR_STATUS;
          tmo_cnt_d = 8'd0;
        end
      end

      StRdStatus, StRdTime: begin
        if (wbm.wbm_ack_i) begin
          data_d  = wbm.wbm_dat_i;
          cyc_d   = 1'b0;
          adr_d   = 32'h0;
          state_d = (state_q == StRdStatus) ? StChk : StPush;
        end else if (tmo_cnt_q == TmoLast) begin
          // Abandon the cycle; assigned after clr_i so a coincident timeout wins.
          cyc_d   = 1'b0;
          adr_d   = 32'h0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      StChk: begin
        // Only fetch the time word when it has somewhere to go, so the slave
        // keeps the timestamp pending while the FIFO is full.
        if (data_q[0] && !fifo_full_o) begin
          state_d   = StRdTime;
          cyc_d     = 1'b1;
          adr_d     = ADDR_TIME;
          tmo_cnt_d = 8'd0;
        end else begin
          state_d = StIdle;
        end
      end

      StPush: begin
        push    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      adr_q     <= 32'h0;
      data_q    <= 32'h0;
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  // FIFO: pointers wrap naturally because the depth is a power of two.
  assign pop          = fifo_rd_i && !fifo_empty_o;
  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_dat_o   = fifo_empty_o ? 32'h0 : mem[rd_ptr_q];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are masked by the empty flag.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_tdc_wb_reader.sv
module tb_tdc_wb_reader;
  localparam logic [31:0] AddrStatus = 32'h3000_0000;
  localparam logic [31:0] AddrTime   = 32'h3000_0004;
  localparam int          Timeout    = 16;
  localparam int          Depth      = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        enable_i;
  logic        clr_i;
  logic        fifo_rd_i;
  logic [31:0] fifo_dat_o;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic        err_timeout_o;

  tdc_wb_reader_if wbm ();

  tdc_wb_reader #(
    .ADDR_STATUS (AddrStatus),
    .ADDR_TIME   (AddrTime),
    .TIMEOUT     (Timeout),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .enable_i      (enable_i),
    .clr_i         (clr_i),
    .wbm           (wbm),
    .fifo_rd_i     (fifo_rd_i),
    .fifo_dat_o    (fifo_dat_o),
    .fifo_empty_o  (fifo_empty_o),
    .fifo_full_o   (fifo_full_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] model_q[$];      // expected FIFO contents, head first
  logic [31:0] offer_q[$];      // timestamps the TDC will produce, in order
  logic [31:0] pop_log[$];      // DUT head values observed at each pop
  logic [31:0] start_adr_q[$];  // address of every bus cycle start
  int          start_cyc_q[$];  // edge number of every bus cycle start
  int          cyc_n, wait_cnt, scnt, lat, fixed_lat, size_prev, last_done_cyc, n0, nst;
  logic        cyc_prev, empty_prev, pending, push_pend, noack_cur, force_noack;
  logic        rand_noack, stray_req, last_bit, exp_err, timed_out;
  logic [31:0] adr_prev, dat_prev, ts_val, push_val, ack_data, last_done_adr, tmp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model/slave update at posedge+1, returns at the next negedge.
  task automatic step();
    logic ack_s, rd_s, clr_s, cyc;
    @(posedge wb_clk_i);
    #1;
    cyc_n++;
    ack_s = wbm.wbm_ack_i;
    rd_s  = fifo_rd_i;
    clr_s = clr_i;
    cyc   = wbm.wbm_cyc_o;
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_dat_i = $urandom();
    if (wb_rst_i) begin
      model_q.delete();
      exp_err   = 1'b0;
      push_pend = 1'b0;
      wait_cnt  = 0;
      scnt      = 0;
    end else begin
      if (rd_s && !empty_prev) pop_log.push_back(dat_prev);
      if (rd_s && model_q.size() > 0) void'(model_q.pop_front());
      if (push_pend) begin
        check("push_room", 32'(size_prev < Depth), 32'd1);
        model_q.push_back(push_val);
        push_pend = 1'b0;
      end
      timed_out = 1'b0;
      if (cyc_prev && ack_s) begin
        check("cyc_drop_on_ack", 32'(cyc), 32'd0);
        if (adr_prev == AddrTime) begin
          check("time_read_pending", 32'(pending), 32'd1);
          push_pend = 1'b1;
          push_val  = ack_data;
          pending   = 1'b0;
          last_bit  = 1'b0;
        end else begin
          last_bit = ack_data[0];
        end
        last_done_adr = adr_prev;
        last_done_cyc = cyc_n;
        wait_cnt      = 0;
      end else if (cyc_prev) begin
        wait_cnt++;
        if (wait_cnt == Timeout) begin
          timed_out = 1'b1;
          check("cyc_drop_timeout", 32'(cyc), 32'd0);
          last_done_adr = 32'h0;
        end else begin
          check("cyc_hold", 32'(cyc), 32'd1);
          check("adr_hold", wbm.wbm_adr_o, adr_prev);
        end
      end else begin
        wait_cnt = 0;
      end
      if (clr_s) exp_err = 1'b0;
      if (timed_out) exp_err = 1'b1;

      if (cyc && !cyc_prev) begin
        start_adr_q.push_back(wbm.wbm_adr_o);
        start_cyc_q.push_back(cyc_n);
        check("start_room", 32'(size_prev < Depth), 32'd1);
        if (wbm.wbm_adr_o == AddrTime)
          check("time_after_status", 32'(last_done_adr == AddrStatus && last_bit
                && last_done_cyc == cyc_n - 1), 32'd1);
        else
          check("start_adr", wbm.wbm_adr_o, AddrStatus);
      end

      check("we", 32'(wbm.wbm_we_o), 32'd0);
      check("dat_o", wbm.wbm_dat_o, 32'd0);
      check("stb", 32'(wbm.wbm_stb_o), 32'(cyc));
      check("sel", 32'(wbm.wbm_sel_o), cyc ? 32'hF : 32'h0);
      if (!cyc) check("adr_idle", wbm.wbm_adr_o, 32'h0);
      check("fifo_empty", 32'(fifo_empty_o), 32'(model_q.size() == 0));
      check("fifo_full", 32'(fifo_full_o), 32'(model_q.size() == Depth));
      check("fifo_dat", fifo_dat_o, (model_q.size() > 0) ? model_q[0] : 32'h0);
      check("err_timeout", 32'(err_timeout_o), 32'(exp_err));

      // Slave: acks lat cycles after it first sees the strobe.
      if (cyc) begin
        scnt++;
        if (scnt == 1) begin
          lat       = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
          noack_cur = force_noack || (rand_noack && $urandom_range(0, 15) == 0);
        end
        if (!noack_cur && scnt == lat + 1) begin
          tmp    = $urandom();
          tmp[0] = pending;
          ack_data      = (wbm.wbm_adr_o == AddrTime) ? ts_val : tmp;
          wbm.wbm_ack_i = 1'b1;
          wbm.wbm_dat_i = ack_data;
        end
      end else begin
        scnt = 0;
        if (stray_req) begin
          wbm.wbm_ack_i = 1'b1;
          stray_req     = 1'b0;
        end
      end
      if (!pending && offer_q.size() > 0) begin
        pending = 1'b1;
        ts_val  = offer_q.pop_front();
      end
    end
    cyc_prev   = wbm.wbm_cyc_o;
    adr_prev   = wbm.wbm_adr_o;
    size_prev  = model_q.size();
    empty_prev = fifo_empty_o;
    dat_prev   = fifo_dat_o;
    @(negedge wb_clk_i);
  endtask

  initial begin
    logic [31:0] exp_seq[5];
    wb_rst_i = 1'b1; enable_i = 1'b0; clr_i = 1'b0; fifo_rd_i = 1'b0;
    wbm.wbm_ack_i = 1'b0; wbm.wbm_dat_i = 32'h0;
    cyc_n = 0; wait_cnt = 0; scnt = 0; lat = 1; fixed_lat = 1; size_prev = 0;
    last_done_cyc = 0; cyc_prev = 1'b0; empty_prev = 1'b1; pending = 1'b0;
    push_pend = 1'b0; noack_cur = 1'b0; force_noack = 1'b0; rand_noack = 1'b0;
    stray_req = 1'b0; last_bit = 1'b0; exp_err = 1'b0; adr_prev = 32'h0; dat_prev = 32'h0;
    ts_val = 32'h0; push_val = 32'h0; ack_data = 32'h0; last_done_adr = 32'h0;
    @(negedge wb_clk_i);
    step(); step();
    check("rst_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm.wbm_stb_o), 32'd0);
    check("rst_sel", 32'(wbm.wbm_sel_o), 32'd0);
    check("rst_adr", wbm.wbm_adr_o, 32'd0);
    check("rst_empty", 32'(fifo_empty_o), 32'd1);
    check("rst_full", 32'(fifo_full_o), 32'd0);
    check("rst_dat", fifo_dat_o, 32'd0);
    check("rst_err", 32'(err_timeout_o), 32'd0);
    wb_rst_i = 1'b0;
    step();

    // Single timestamp with single-cycle acks: latency and addresses.
    offer_q.push_back(32'h0000_1234);
    step(); step();
    start_adr_q.delete(); start_cyc_q.delete(); pop_log.delete();
    enable_i = 1'b1;
    n0 = cyc_n + 1;
    step();
    enable_i = 1'b0;
    repeat (5) step();
    check("t1_empty_n5", 32'(fifo_empty_o), 32'd1);
    step();
    check("t1_empty_n6", 32'(fifo_empty_o), 32'd0);
    check("t1_dat_n6", fifo_dat_o, 32'h0000_1234);
    repeat (4) step();
    check("t1_cycles", start_adr_q.size(), 32'd2);
    if (start_adr_q.size() >= 2) begin
      check("t1_adr0", start_adr_q[0], AddrStatus);
      check("t1_adr1", start_adr_q[1], AddrTime);
      check("t1_start0", start_cyc_q[0], n0);
      check("t1_start1", start_cyc_q[1], n0 + 3);
    end
    fifo_rd_i = 1'b1; step(); fifo_rd_i = 1'b0;
    check("t1_pop_cnt", pop_log.size(), 32'd1);
    if (pop_log.size() > 0) check("t1_pop", pop_log[0], 32'h0000_1234);

    // Status always 0: status-only polls every 4 cycles.
    start_adr_q.delete(); start_cyc_q.delete();
    enable_i = 1'b1;
    repeat (21) step();
    enable_i = 1'b0;
    repeat (6) step();
    check("t2_polls", start_adr_q.size(), 32'd6);
    for (int i = 0; i < start_adr_q.size(); i++) begin
      check("t2_adr", start_adr_q[i], AddrStatus);
      if (i > 0) check("t2_gap", start_cyc_q[i] - start_cyc_q[i-1], 32'd4);
    end
    check("t2_empty", 32'(fifo_empty_o), 32'd1);

    // Slave never acks: timeout, sticky error, stray ack, clear.
    start_adr_q.delete(); start_cyc_q.delete();
    force_noack = 1'b1;
    enable_i = 1'b1; step(); enable_i = 1'b0;
    repeat (Timeout + 3) step();
    check("t3_err", 32'(err_timeout_o), 32'd1);
    check("t3_cycles", start_adr_q.size(), 32'd1);
    check("t3_empty", 32'(fifo_empty_o), 32'd1);
    stray_req = 1'b1;
    repeat (3) step();
    check("t3_stray_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("t3_stray_err", 32'(err_timeout_o), 32'd1);
    check("t3_stray_cycles", start_adr_q.size(), 32'd1);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    check("t3_clr", 32'(err_timeout_o), 32'd0);
    force_noack = 1'b0;

    // Fill the FIFO, confirm the bus goes quiet, then check ordering.
    fixed_lat = 0;
    pop_log.delete();
    exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    foreach (exp_seq[i]) offer_q.push_back(exp_seq[i]);
    enable_i = 1'b1;
    for (int i = 0; i < 400 && !fifo_full_o; i++) step();
    check("t4_full", 32'(fifo_full_o), 32'd1);
    nst = start_adr_q.size();
    repeat (12) step();
    check("t4_no_bus", start_adr_q.size(), nst);
    fifo_rd_i = 1'b1; step(); fifo_rd_i = 1'b0;
    check("t4_first_pop_cnt", pop_log.size(), 32'd1);
    if (pop_log.size() > 0) check("t4_first_pop", pop_log[0], 32'hA);
    for (int i = 0; i < 400 && !fifo_full_o; i++) step();
    check("t4_refull", 32'(fifo_full_o), 32'd1);
    enable_i = 1'b0;
    fifo_rd_i = 1'b1; repeat (4) step(); fifo_rd_i = 1'b0;
    step();
    check("t4_pops", pop_log.size(), 32'd5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++) check("t4_order", pop_log[i], exp_seq[i]);
    check("t4_empty", 32'(fifo_empty_o), 32'd1);

    // Pop on the PUSH edge with two entries stored.
    pop_log.delete();
    offer_q.push_back(32'h11); offer_q.push_back(32'h22);
    enable_i = 1'b1;
    for (int i = 0; i < 400 && model_q.size() < 2; i++) step();
    offer_q.push_back(32'h33);
    for (int i = 0; i < 400 && !push_pend; i++) step();
    check("t5_push_seen", 32'(push_pend), 32'd1);
    fifo_rd_i = 1'b1; step(); fifo_rd_i = 1'b0;
    enable_i = 1'b0;
    check("t5_not_empty", 32'(fifo_empty_o), 32'd0);
    check("t5_not_full", 32'(fifo_full_o), 32'd0);
    fifo_rd_i = 1'b1; step(); fifo_rd_i = 1'b0;
    check("t5_one_left", 32'(fifo_empty_o), 32'd0);
    fifo_rd_i = 1'b1; step(); fifo_rd_i = 1'b0;
    check("t5_drained", 32'(fifo_empty_o), 32'd1);
    check("t5_pops", pop_log.size(), 32'd3);
    if (pop_log.size() == 3) begin
      check("t5_order0", pop_log[0], 32'h11);
      check("t5_order1", pop_log[1], 32'h22);
      check("t5_order2", pop_log[2], 32'h33);
    end
    repeat (8) step();

    // Reset while the time read is on the bus.
    fixed_lat = 3;
    offer_q.push_back(32'h66); offer_q.push_back(32'h77);
    enable_i = 1'b1;
    for (int i = 0; i < 400 && model_q.size() < 1; i++) step();
    for (int i = 0; i < 400 && !(wbm.wbm_cyc_o && wbm.wbm_adr_o == AddrTime); i++) step();
    check("t6_in_rd_time", 32'(wbm.wbm_cyc_o && wbm.wbm_adr_o == AddrTime), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("t6_cyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("t6_stb", 32'(wbm.wbm_stb_o), 32'd0);
    check("t6_adr", wbm.wbm_adr_o, 32'd0);
    check("t6_empty", 32'(fifo_empty_o), 32'd1);
    step(); step();
    wb_rst_i = 1'b0;
    start_adr_q.delete(); start_cyc_q.delete();
    for (int i = 0; i < 20 && start_adr_q.size() == 0; i++) step();
    check("t6_restart", start_adr_q.size() > 0 ? start_adr_q[0] : 32'hDEAD_BEEF, AddrStatus);

    // Randomized traffic against the model.
    fixed_lat = 0;
    rand_noack = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      enable_i  = ($urandom_range(0, 3) != 0);
      fifo_rd_i = ($urandom_range(0, 2) == 0);
      clr_i     = ($urandom_range(0, 15) == 0);
      if (offer_q.size() == 0 && $urandom_range(0, 5) == 0) offer_q.push_back($urandom());
      step();
    end
    rand_noack = 1'b0;
    clr_i = 1'b0; enable_i = 1'b1; fifo_rd_i = 1'b1;
    for (int i = 0; i < 600 && (pending || offer_q.size() > 0 || push_pend
         || model_q.size() > 0); i++) step();
    enable_i = 1'b0;
    repeat (8) step();
    fifo_rd_i = 1'b0;
    step();
    check("drain_pending", 32'(pending), 32'd0);
    check("drain_empty", 32'(fifo_empty_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
